// File: rtl/write_pointer_full_if.sv
// Write-side FIFO pointer bundle.
// The slave modport is the pointer/full generator.
// The master modport is the producer/environment: it drives push and the
// already-synchronized read pointer, and it observes the flags.
interface write_pointer_full_if #(
  parameter int ADDR_WIDTH = 4
) ();

  logic                  push;
  logic [ADDR_WIDTH:0]   rptr_gray_sync;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  write_enable;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   free_slots;
  logic                  overflow;

  modport master (
    output push,
    output rptr_gray_sync,
    input  wptr_gray,
    input  waddr,
    input  write_enable,
    input  full,
    input  almost_full,
    input  free_slots,
    input  overflow
  );

  modport slave (
    input  push,
    input  rptr_gray_sync,
    output wptr_gray,
    output waddr,
    output write_enable,
    output full,
    output almost_full,
    output free_slots,
    output overflow
  );

endinterface

// File: rtl/write_pointer_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// It keeps an (ADDR_WIDTH+1)-bit binary write pointer. The extra MSB tells a
// full FIFO apart from an empty one.
// It publishes the Gray form of that pointer straight from a flop, so the
// read-domain synchronizer never samples combinational glitches.
// full, almost_full and free_slots are computed from the next write pointer
// and the synchronized read pointer, and they are registered. A push accepted
// at an edge is therefore reflected in the flags right after that edge.
module write_pointer_full #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                 ptr_clock,
  input  logic                 ptr_reset,
  write_pointer_full_if.slave  wr
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  // Depth expressed in pointer width so it can represent the value DEPTH.
  localparam logic [PTR_W-1:0] DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] MARGIN_V = PTR_W'(ALMOST_FULL_MARGIN);
  localparam logic [PTR_W-1:0] ZERO_V   = {PTR_W{1'b0}};

  // Binary to reflected Gray code.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary (XOR prefix starting at the MSB).
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray code the write pointer must equal when the FIFO holds DEPTH entries.
  // Invert the top two bits of the read pointer and keep the remaining bits.
  function automatic logic [PTR_W-1:0] full_pattern(input logic [PTR_W-1:0] rg);
    return {~rg[PTR_W-1:PTR_W-2], rg[PTR_W-3:0]};
  endfunction

  // State registers.
  logic [PTR_W-1:0] wbin_q,        wbin_d;
  logic [PTR_W-1:0] wgray_q,       wgray_d;
  logic             full_q,        full_d;
  logic             almost_full_q, almost_full_d;
  logic [PTR_W-1:0] free_slots_q,  free_slots_d;
  logic             overflow_q,    overflow_d;

  // Combinational intermediates.
  logic             write_enable_s;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] used_s;

  // write_enable depends only on push and the registered full flag. The read
  // pointer therefore has no combinational path to any output.
  assign write_enable_s = wr.push & ~full_q;

  // Next-state computation for the pointer, the flags and the sticky overflow.
  always_comb begin
    wbin_d        = wbin_q;
    wgray_d       = wgray_q;
    rbin_s        = ZERO_V;
    used_s        = ZERO_V;
    full_d        = 1'b0;
    almost_full_d = 1'b0;
    free_slots_d  = DEPTH_V;
    overflow_d    = overflow_q;

    // The pointer advances only on an accepted write and wraps modulo 2^PTR_W.
    wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, write_enable_s};
    wgray_d = bin2gray(wbin_d);

    // Occupancy uses the next write pointer, so a push and a read advance in
    // the same cycle are both accounted for.
    rbin_s       = gray2bin(wr.rptr_gray_sync);
    used_s       = wbin_d - rbin_s;
    free_slots_d = DEPTH_V - used_s;

    full_d        = (wgray_d == full_pattern(wr.rptr_gray_sync));
    almost_full_d = (free_slots_d <= MARGIN_V);

    // A rejected push is recorded and kept until reset.
    overflow_d = overflow_q | (wr.push & full_q);
  end

  // Pointer and flag registers, cleared asynchronously by ptr_reset.
  always_ff @(posedge ptr_clock or posedge ptr_reset) begin
    if (ptr_reset) begin
      wbin_q        <= ZERO_V;
      wgray_q       <= ZERO_V;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      free_slots_q  <= DEPTH_V;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      free_slots_q  <= free_slots_d;
      overflow_q    <= overflow_d;
    end
  end

  // Outputs come straight from flops, except write_enable. The memory needs
  // write_enable in the same cycle as push.
  assign wr.wptr_gray    = wgray_q;
  assign wr.waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wr.write_enable = write_enable_s;
  assign wr.full         = full_q;
  assign wr.almost_full  = almost_full_q;
  assign wr.free_slots   = free_slots_q;
  assign wr.overflow     = overflow_q;

endmodule

// File: tb/tb_write_pointer_full.sv
// Self-checking bench for write_pointer_full (ADDR_WIDTH=4, margin 2).
// Reference model: unbounded counts of accepted writes and reads. Occupancy is
// their difference, and the flags follow directly from that occupancy.
module tb_write_pointer_full;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  write_pointer_full_if #(.ADDR_WIDTH(AW)) bus ();

  write_pointer_full #(
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .ptr_clock(clk),
    .ptr_reset(rst),
    .wr(bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state.
  int m_w;     // total accepted writes since reset
  int m_r;     // total reads reflected by rptr_gray_sync
  int m_free;
  bit m_full;
  bit m_af;
  bit m_ovf;

  function automatic logic [4:0] gray_of(input int n);
    int m;
    m = n % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  function automatic logic [17:0] exp_vec();
    return {gray_of(m_w), 4'(m_w % DEPTH), bus.push & ~m_full, m_full, m_af,
            5'(m_free), m_ovf};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.wptr_gray, bus.waddr, bus.write_enable, bus.full, bus.almost_full,
            bus.free_slots, bus.overflow};
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_free = DEPTH; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock: drive push and the read count at the falling edge, then update
  // the model at the rising edge and settle 1 time unit.
  task automatic drive(input bit p, input int rc);
    @(negedge clk);
    bus.push           = p;
    bus.rptr_gray_sync = gray_of(rc);
    @(posedge clk);
    if (p && m_full) m_ovf = 1'b1;
    if (p && !m_full) m_w++;
    m_r    = rc;
    m_free = DEPTH - (m_w - m_r);
    m_full = (m_free == 0);
    m_af   = (m_free <= MARGIN);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] want;
    bus.push = 1'b0;
    bus.rptr_gray_sync = 5'b00000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    want = {5'b00000, 4'h0, 1'b0, 1'b0, 1'b0, 5'd16, 1'b0};
    if (obs_vec() !== want) begin
      $display("FAIL reset_state got %h want %h", obs_vec(), want);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 0);
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_mid_fill();
    logic [17:0] want;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0);
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL midfill_push%0d got %h want %h", i, obs_vec(), exp_vec());
        miscompares++;
      end
      vectors++;
    end
    @(negedge clk);
    #1;
    bus.push = 1'b1;
    rst = 1'b1;
    #1;
    // No clock edge has happened since reset rose.
    want = {5'b00000, 4'h0, 1'b1, 1'b0, 1'b0, 5'd16, 1'b0};
    if (obs_vec() !== want) begin
      $display("FAIL async_reset got %h want %h", obs_vec(), want);
      miscompares++;
    end
    vectors++;
    rst = 1'b0;
    bus.push = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    logic [4:0] seq [4];
    seq = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 0);
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL fill_push%0d got %h want %h", i, obs_vec(), exp_vec());
        miscompares++;
      end
      vectors++;
      if (i <= 4) begin
        if (bus.wptr_gray !== seq[i-1]) begin
          $display("FAIL fill_gray%0d got %b want %b", i, bus.wptr_gray, seq[i-1]);
          miscompares++;
        end
        vectors++;
      end
      if (i == 13 || i == 14) begin
        if (bus.almost_full !== (i == 14)) begin
          $display("FAIL fill_af%0d got %b want %b", i, bus.almost_full, (i == 14));
          miscompares++;
        end
        vectors++;
      end
    end
    if ({bus.full, bus.wptr_gray, bus.free_slots} !== {1'b1, 5'b11000, 5'd0}) begin
      $display("FAIL fill_full got %b/%b/%0d want 1/11000/0",
               bus.full, bus.wptr_gray, bus.free_slots);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0);
      if ({bus.write_enable, bus.wptr_gray, bus.overflow} !== {1'b0, 5'b11000, 1'b1}) begin
        $display("FAIL overflow%0d got we=%b g=%b ovf=%b want 0/11000/1",
                 i, bus.write_enable, bus.wptr_gray, bus.overflow);
        miscompares++;
      end
      vectors++;
    end
    drive(1'b0, 0);
    if (obs_vec() !== exp_vec() || bus.overflow !== 1'b1) begin
      $display("FAIL overflow_sticky got %h want %h", obs_vec(), exp_vec());
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_release();
    drive(1'b0, 1);
    if ({bus.full, bus.free_slots, bus.almost_full} !== {1'b0, 5'd1, 1'b1}) begin
      $display("FAIL release got full=%b free=%0d af=%b want 0/1/1",
               bus.full, bus.free_slots, bus.almost_full);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 2);
    if ({bus.free_slots, bus.full, bus.write_enable} !== {5'd1, 1'b0, 1'b1}) begin
      $display("FAIL simultaneous got free=%0d full=%b we=%b want 1/0/1",
               bus.free_slots, bus.full, bus.write_enable);
      miscompares++;
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL simultaneous_vec got %h want %h", obs_vec(), exp_vec());
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    int wraps;
    wraps = 0;
    prev  = bus.wptr_gray;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, m_w - 3);
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL wrap_vec%0d got %h want %h", i, obs_vec(), exp_vec());
        miscompares++;
      end
      vectors++;
      if ($countones(bus.wptr_gray ^ prev) > 1) begin
        $display("FAIL wrap_hamming%0d got %b after %b want <=1 bit change",
                 i, bus.wptr_gray, prev);
        miscompares++;
      end
      vectors++;
      if (m_w % 32 == 0) begin
        wraps++;
        if ({prev, bus.wptr_gray} !== {5'b10000, 5'b00000}) begin
          $display("FAIL wrap_edge got %b->%b want 10000->00000", prev, bus.wptr_gray);
          miscompares++;
        end
        vectors++;
      end
      prev = bus.wptr_gray;
    end
    if (wraps != 1) begin
      $display("FAIL wrap_count got %0d want 1", wraps);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [4:0] prev;
    int rc;
    bit p;
    @(negedge clk);
    bus.push = 1'b0;
    bus.rptr_gray_sync = 5'b00000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    prev = bus.wptr_gray;
    for (int i = 0; i < 300; i++) begin
      p  = ($urandom_range(0, 2) != 0);
      rc = m_r;
      if (m_r < m_w && $urandom_range(0, 2) == 0) rc = m_r + 1;
      drive(p, rc);
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random%0d got %h want %h", i, obs_vec(), exp_vec());
        miscompares++;
      end
      vectors++;
      if ($countones(bus.wptr_gray ^ prev) > 1) begin
        $display("FAIL random_hamming%0d got %b after %b want <=1 bit change",
                 i, bus.wptr_gray, prev);
        miscompares++;
      end
      vectors++;
      prev = bus.wptr_gray;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_fill();
    test_overflow();
    test_release();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
